can_rx_frame_decoder: RTL and testbench

Receive-side counterpart of the CAN transmit CRC path: consumes the sampled serial bit stream from the bit-timing logic, removes stuff bits, and parses base-format (11-bit ID) data/remote frames. It checks the serial CRC-15 (poly 0x4599), stuff rule and fixed-form fields. It presents ID, DLC and up to 8 data bytes with a one-cycle valid pulse, or a one-cycle error pulse, to the controller core.

---
 rtl/can_rx_frame_decoder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_can_rx_frame_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_rx_frame_decoder.sv
// rtl/can_rx_frame_decoder.sv - CAN base-format frame receiver: destuffing, CRC-15 check, field parse
// Optional ACK indication output enabled by defining CAN_RX_ACK_EN.
module can_rx_frame_decoder #(
    parameter int EOF_BITS  = 7,
    parameter int IDLE_BITS = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_valid,
    input  logic        rx_bit,
    output logic [10:0] rx_id,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [63:0] rx_data,
    output logic        rx_valid,
    output logic        crc_error,
    output logic        stuff_error,
    output logic        form_error,
`ifdef CAN_RX_ACK_EN
    output logic        ack_o,
`endif
    output logic        busy
);

    localparam int REC_W = $clog2(IDLE_BITS + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARB,
        S_CTRL,
        S_DATA,
        S_CRC,
        S_CRC_DEL,
        S_ACK_SLOT,
        S_ACK_DEL,
        S_EOF,
        S_RECOVER
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         bit_cnt_q, bit_cnt_d;
    logic [14:0]        crc_q, crc_d;
    logic [2:0]         stuff_cnt_q, stuff_cnt_d;
    logic               last_q, last_d;
    logic [REC_W-1:0]   rec_cnt_q, rec_cnt_d;
    logic [10:0]        id_q, id_d;
    logic               rtr_q, rtr_d;
    logic [3:0]         dlc_q, dlc_d;
    logic [6:0]         nbits_q, nbits_d;
    logic [63:0]        data_q, data_d;
    logic [3:0]         dlc_next;
    logic               valid_d, crc_err_d, stuff_err_d, form_err_d;
    logic               in_stuff_zone;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic n;
        n = b ^ c[14];
        return {c[13:0], 1'b0} ^ (n ? 15'h4599 : 15'h0000);
    endfunction

    assign busy          = (state_q != S_IDLE);
    assign in_stuff_zone = (state_q inside {S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL});

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        stuff_cnt_d = stuff_cnt_q;
        last_d      = last_q;
        rec_cnt_d   = rec_cnt_q;
        id_d        = id_q;
        rtr_d       = rtr_q;
        dlc_d       = dlc_q;
        nbits_d     = nbits_q;
        data_d      = data_q;
        dlc_next    = {dlc_q[2:0], rx_bit};
        valid_d     = 1'b0;
        crc_err_d   = 1'b0;
        stuff_err_d = 1'b0;
        form_err_d  = 1'b0;

        if (bit_valid) begin
            if (in_stuff_zone && stuff_cnt_q == 3'd5) begin
                // Sixth bit after a run of five: must be a complementary stuff bit.
                if (rx_bit == last_q) begin
                    stuff_err_d = 1'b1;
                    state_d     = S_RECOVER;
                    rec_cnt_d   = '0;
                end else begin
                    stuff_cnt_d = 3'd1;
                    last_d      = rx_bit;
                end
            end else begin
                if (state_q inside {S_ARB, S_CTRL, S_DATA, S_CRC}) begin
                    stuff_cnt_d = (rx_bit == last_q) ? stuff_cnt_q + 3'd1 : 3'd1;
                    last_d      = rx_bit;
                    crc_d       = crc_step(crc_q, rx_bit);
                end

                case (state_q)
                    S_IDLE: begin
                        if (!rx_bit) begin
                            state_d     = S_ARB;
                            crc_d       = crc_step(15'h0000, 1'b0);
                            stuff_cnt_d = 3'd1;
                            last_d      = 1'b0;
                            bit_cnt_d   = '0;
                            data_d      = '0;
                        end
                    end
                    S_ARB: begin
                        if (bit_cnt_q == 7'd11) begin
                            rtr_d     = rx_bit;
                            state_d   = S_CTRL;
                            bit_cnt_d = '0;
                        end else begin
                            id_d      = {id_q[9:0], rx_bit};
                            bit_cnt_d = bit_cnt_q + 7'd1;
                        end
                    end
                    S_CTRL: begin
                        if (bit_cnt_q == 7'd0 && rx_bit) begin
                            form_err_d = 1'b1;
                            state_d    = S_RECOVER;
                            rec_cnt_d  = '0;
                        end else begin
                            if (bit_cnt_q >= 7'd2)
                                dlc_d = dlc_next;
                            if (bit_cnt_q == 7'd5) begin
                                if (rtr_q)
                                    nbits_d = 7'd0;
                                else if (dlc_next > 4'd8)
                                    nbits_d = 7'd64;
                                else
                                    nbits_d = {dlc_next, 3'b000};
                                state_d   = (rtr_q || dlc_next == 4'd0) ? S_CRC : S_DATA;
                                bit_cnt_d = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 7'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        // Byte 0 lands in [63:56]; untouched bytes stay cleared from SOF.
                        data_d[~bit_cnt_q[5:0]] = rx_bit;
                        if (bit_cnt_q == nbits_q - 7'd1) begin
                            state_d   = S_CRC;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                        end
                    end
                    S_CRC: begin
                        if (bit_cnt_q == 7'd14) begin
                            state_d   = S_CRC_DEL;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                        end
                    end
                    S_CRC_DEL: begin
                        if (!rx_bit) begin
                            form_err_d = 1'b1;
                            state_d    = S_RECOVER;
                            rec_cnt_d  = '0;
                        end else if (crc_q != 15'h0000) begin
                            crc_err_d = 1'b1;
                            state_d   = S_RECOVER;
                            rec_cnt_d = '0;
                        end else begin
                            state_d = S_ACK_SLOT;
                        end
                    end
                    S_ACK_SLOT: begin
                        state_d = S_ACK_DEL;
                    end
                    S_ACK_DEL: begin
                        if (!rx_bit) begin
                            form_err_d = 1'b1;
                            state_d    = S_RECOVER;
                            rec_cnt_d  = '0;
                        end else begin
                            state_d   = S_EOF;
                            bit_cnt_d = '0;
                        end
                    end
                    S_EOF: begin
                        if (!rx_bit) begin
                            form_err_d = 1'b1;
                            state_d    = S_RECOVER;
                            rec_cnt_d  = '0;
                        end else if (bit_cnt_q == 7'(EOF_BITS - 1)) begin
                            valid_d   = 1'b1;
                            state_d   = S_IDLE;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                        end
                    end
                    S_RECOVER: begin
                        if (!rx_bit) begin
                            rec_cnt_d = '0;
                        end else if (rec_cnt_q == REC_W'(IDLE_BITS - 1)) begin
                            rec_cnt_d = '0;
                            state_d   = S_IDLE;
                        end else begin
                            rec_cnt_d = rec_cnt_q + 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            crc_q       <= '0;
            stuff_cnt_q <= '0;
            last_q      <= 1'b0;
            rec_cnt_q   <= '0;
            id_q        <= '0;
            rtr_q       <= 1'b0;
            dlc_q       <= '0;
            nbits_q     <= '0;
            data_q      <= '0;
            rx_id       <= '0;
            rx_rtr      <= 1'b0;
            rx_dlc      <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            crc_error   <= 1'b0;
            stuff_error <= 1'b0;
            form_error  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            crc_q       <= crc_d;
            stuff_cnt_q <= stuff_cnt_d;
            last_q      <= last_d;
            rec_cnt_q   <= rec_cnt_d;
            id_q        <= id_d;
            rtr_q       <= rtr_d;
            dlc_q       <= dlc_d;
            nbits_q     <= nbits_d;
            data_q      <= data_d;
            rx_valid    <= valid_d;
            crc_error   <= crc_err_d;
            stuff_error <= stuff_err_d;
            form_error  <= form_err_d;
            if (valid_d) begin
                rx_id   <= id_q;
                rx_rtr  <= rtr_q;
                rx_dlc  <= dlc_q;
                rx_data <= data_q;
            end
        end
    end

`ifdef CAN_RX_ACK_EN
    // High exactly while the ACK slot is pending after a clean CRC delimiter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ack_o <= 1'b0;
        else
            ack_o <= (state_d == S_ACK_SLOT);
    end
`endif

endmodule

// File: tb/tb_can_rx_frame_decoder.sv
// tb/tb_can_rx_frame_decoder.sv - scoreboard bench for can_rx_frame_decoder (optional CAN_RX_ACK_EN)
module tb_can_rx_frame_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_valid = 1'b0;
    logic        rx_bit = 1'b1;
    logic [10:0] rx_id;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        rx_valid, crc_error, stuff_error, form_error, busy;
`ifdef CAN_RX_ACK_EN
    logic        ack_o;
    logic        ack_seen = 1'b0;
`endif

    can_rx_frame_decoder #(.EOF_BITS(7), .IDLE_BITS(11)) dut (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .rx_bit(rx_bit),
        .rx_id(rx_id), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc), .rx_data(rx_data),
        .rx_valid(rx_valid), .crc_error(crc_error), .stuff_error(stuff_error),
        .form_error(form_error),
`ifdef CAN_RX_ACK_EN
        .ack_o(ack_o),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    localparam int K_VALID = 0, K_CRC = 1, K_STUFF = 2, K_FORM = 3;

    typedef struct {
        int          kind;
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   gap_max = 0;
    logic fb[$];
    int   stuff_pos[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic push_exp(input int kind, input logic [10:0] id, input logic rtr,
                            input logic [3:0] dlc, input logic [63:0] data);
        exp_t e;
        e.kind = kind; e.id = id; e.rtr = rtr; e.dlc = dlc; e.data = data;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   k;
`ifdef CAN_RX_ACK_EN
        if (ack_o) ack_seen = 1'b1;
`endif
        if (rst_n && (rx_valid | crc_error | stuff_error | form_error)) begin
            k = rx_valid ? K_VALID : crc_error ? K_CRC : stuff_error ? K_STUFF : K_FORM;
            chk("one_pulse", 64'($countones({rx_valid, crc_error, stuff_error, form_error})), 64'd1);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got kind %0d expected none", k);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", 64'(k), 64'(e.kind));
                if (e.kind == K_VALID) begin
                    chk("rx_id", 64'(rx_id), 64'(e.id));
                    chk("rx_rtr", 64'(rx_rtr), 64'(e.rtr));
                    chk("rx_dlc", 64'(rx_dlc), 64'(e.dlc));
                    chk("rx_data", rx_data, e.data);
                end
            end
        end
    end

    function automatic logic [14:0] crc_next(input logic [14:0] c, input logic b);
        logic fb_bit;
        fb_bit = b ^ c[14];
        crc_next = {c[13:0], 1'b0};
        if (fb_bit) crc_next = crc_next ^ 15'h4599;
    endfunction

    task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] data, input bit flip_crc0);
        logic        d[$];
        logic [14:0] c;
        logic        last;
        int          cnt, nb;
        d = {};
        d.push_back(1'b0);
        for (int i = 10; i >= 0; i--) d.push_back(id[i]);
        d.push_back(rtr);
        d.push_back(1'b0);
        d.push_back(1'b0);
        for (int i = 3; i >= 0; i--) d.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < nb * 8; i++) d.push_back(data[63 - i]);
        c = '0;
        foreach (d[i]) c = crc_next(c, d[i]);
        if (flip_crc0) c[0] = ~c[0];
        for (int i = 14; i >= 0; i--) d.push_back(c[i]);
        fb = {};
        stuff_pos = {};
        cnt = 0;
        last = 1'b0;
        foreach (d[i]) begin
            fb.push_back(d[i]);
            if (i == 0 || d[i] != last) begin
                cnt = 1;
                last = d[i];
            end else begin
                cnt++;
            end
            if (cnt == 5) begin
                stuff_pos.push_back(fb.size());
                fb.push_back(~last);
                last = ~last;
                cnt = 1;
            end
        end
        fb.push_back(1'b1);
        fb.push_back(1'b0);
        fb.push_back(1'b1);
        repeat (7) fb.push_back(1'b1);
    endtask

    task automatic send_bit(input logic b);
        rx_bit = b;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_fb();
        foreach (fb[i]) send_bit(fb[i]);
    endtask

    task automatic send_idle(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_id"}, 64'(rx_id), 64'd0);
        chk({tag, "_rx_dlc"}, 64'(rx_dlc), 64'd0);
        chk({tag, "_rx_data"}, rx_data, 64'd0);
        chk({tag, "_pulses"}, 64'({rx_valid, crc_error, stuff_error, form_error, rx_rtr}), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int p;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-byte data frame
        gap_max = 0;
        push_exp(K_VALID, 11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000);
        build_frame(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 1'b0);
`ifdef CAN_RX_ACK_EN
        ack_seen = 1'b0;
`endif
        send_fb();
`ifdef CAN_RX_ACK_EN
        chk("ack_good_frame", 64'(ack_seen), 64'd1);
`endif
        send_idle(12);

        // All-zero frame, heavy stuffing, with gaps between bits
        gap_max = 2;
        push_exp(K_VALID, 11'h000, 1'b0, 4'd8, 64'h0);
        build_frame(11'h000, 1'b0, 4'd8, 64'h0, 1'b0);
        send_fb();
        send_idle(12);

        // Same frame with one stuff bit inverted
        build_frame(11'h000, 1'b0, 4'd8, 64'h0, 1'b0);
        p = stuff_pos[2];
        fb[p] = ~fb[p];
        push_exp(K_STUFF, '0, 1'b0, '0, '0);
        send_fb();
        send_idle(12);

        // CRC bit 0 flipped
        gap_max = 1;
        build_frame(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 1'b1);
        push_exp(K_CRC, '0, 1'b0, '0, '0);
`ifdef CAN_RX_ACK_EN
        ack_seen = 1'b0;
`endif
        send_fb();
`ifdef CAN_RX_ACK_EN
        chk("ack_crc_error", 64'(ack_seen), 64'd0);
`endif
        send_idle(12);

        // Remote frame, DLC 15, no data field
        gap_max = 0;
        push_exp(K_VALID, 11'h7FF, 1'b1, 4'd15, 64'h0);
        build_frame(11'h7FF, 1'b1, 4'd15, 64'h0, 1'b0);
        send_fb();
        send_idle(12);

        // DLC 9 clamps to 8 data bytes
        push_exp(K_VALID, 11'h555, 1'b0, 4'd9, 64'h0102_0304_0506_0708);
        build_frame(11'h555, 1'b0, 4'd9, 64'h0102_0304_0506_0708, 1'b0);
        send_fb();
        send_idle(12);

        // Dominant 3rd EOF bit, then recovery counting
        build_frame(11'h0F0, 1'b0, 4'd2, 64'hBEEF_0000_0000_0000, 1'b0);
        repeat (7) void'(fb.pop_back());
        fb.push_back(1'b1);
        fb.push_back(1'b1);
        fb.push_back(1'b0);
        push_exp(K_FORM, '0, 1'b0, '0, '0);
        send_fb();
        send_idle(10);
        send_bit(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_in_recover", 64'(busy), 64'd1);
        send_idle(11);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_after_recover", 64'(busy), 64'd0);

        // Reset in the data field of frame 1, then frame 2
        build_frame(11'h321, 1'b0, 4'd4, 64'hDEAD_BEEF_0000_0000, 1'b0);
        for (int i = 0; i < 30; i++) send_bit(fb[i]);
        chk("busy_mid_frame", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp(K_VALID, 11'h0AB, 1'b0, 4'd2, 64'h1234_0000_0000_0000);
        build_frame(11'h0AB, 1'b0, 4'd2, 64'h1234_0000_0000_0000, 1'b0);
        send_fb();
        send_idle(12);

        repeat (5) @(posedge clk);
        #1;
        chk("expected_left", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
